riscv_dmem_arbiter: RTL and testbench
=====================================

RISCV_DMEM_ARBITER -- requirements
Module: riscv_dmem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter ADDR_BIT, default 12, memory byte-address width forwarded to memory.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, number of consecutive denied M1 cycles before a forced M1 grant (legal range 1..15).
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rstn, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have ports i_m0_req/i_m0_wr_en, input, 1 each, CPU pipeline access request and write flag.
REQ-007 SHALL have ports i_m0_addr (ADDR_BIT), i_m0_byte_sel (4), i_m0_wr_data (XLEN), input, CPU access fields.
REQ-008 SHALL have ports o_m0_gnt, output, 1; o_m0_rd_valid, output, 1; o_m0_rd_data, output, XLEN.
REQ-009 SHALL have ports i_m1_req, i_m1_wr_en, i_m1_lock (1 each), i_m1_addr, i_m1_byte_sel, i_m1_wr_data, input, debug/loader port, same widths as M0.
REQ-010 SHALL have ports o_m1_gnt, o_m1_rd_valid (1 each) and o_m1_rd_data (XLEN), output.
REQ-011 SHALL have ports o_mem_addr (ADDR_BIT), o_mem_wr_en (1), o_mem_byte_sel (4), o_mem_wr_data (XLEN), output, to the data memory.
REQ-012 SHALL have port i_mem_rd_data, input, XLEN, memory read data valid one cycle after the address cycle.

Function
REQ-013 SHALL implement FSM states ARB and LOCK1.
REQ-014 SHALL in ARB grant M0 when i_m0_req=1, except when the starvation counter equals STARVE_LIMIT and i_m1_req=1, in which case M1 is granted.
REQ-015 SHALL in ARB grant M1 when i_m1_req=1 and i_m0_req=0.
REQ-016 SHALL compute grants combinationally in the request cycle; o_mX_gnt=1 means the access is accepted that cycle.
REQ-017 SHALL drive o_mem_* from the granted master's fields; with no grant, o_mem_wr_en=0, o_mem_byte_sel=0, and address/data hold the M0 fields.
REQ-018 SHALL never assert o_m0_gnt and o_m1_gnt in the same cycle.
REQ-019 SHALL increment the 4-bit starvation counter each cycle i_m1_req=1 and M1 is not granted, saturating at STARVE_LIMIT; it clears to 0 on any M1 grant or when i_m1_req=0.
REQ-020 SHALL move ARB->LOCK1 when M1 is granted with i_m1_lock=1; in LOCK1, M1 alone is granted whenever i_m1_req=1, and M0 is never granted.
REQ-021 SHALL move LOCK1->ARB on the first cycle where i_m1_lock=0; that cycle is still arbitrated as LOCK1.
REQ-022 SHALL register a read tag (valid bit + owner) for each granted access with wr_en=0; in the next cycle it asserts the owner's o_mX_rd_valid for exactly one cycle.
REQ-023 SHALL drive o_m0_rd_data and o_m1_rd_data directly from i_mem_rd_data; the data is meaningful only while the matching rd_valid is high.
REQ-024 SHALL allow back-to-back grants every cycle to either master with no bubble, including an M0 read followed by an M1 read.
REQ-025 SHALL give writes no response; a write is complete at grant.

Reset
REQ-026 SHALL, while i_rstn=0 at a rising edge, set FSM=ARB, starvation counter=0, read tag invalid; o_mX_rd_valid=0 the following cycle.
REQ-027 SHALL force o_m0_gnt=0, o_m1_gnt=0, o_mem_wr_en=0 and o_mem_byte_sel=0 combinationally while i_rstn=0.
REQ-028 SHALL discard an outstanding read tag when reset is asserted mid-operation; no rd_valid follows.

Verification
REQ-029 SHALL pass this test: M0 read addr 0x010 alone -> o_m0_gnt=1 same cycle, o_m0_rd_valid=1 next cycle with the memory word at 0x010.
REQ-030 SHALL pass this test: M0 and M1 requesting continuously, STARVE_LIMIT=4 -> M0 granted 4 cycles, M1 on the 5th, then the pattern repeats.
REQ-031 SHALL pass this test: M1 write with lock=1 for 3 cycles while M0 requests -> o_m1_gnt=1 for 3 cycles, o_m0_gnt=0 until lock drops, then M0 granted.
REQ-032 SHALL pass this test: alternating M0 read / M1 read each cycle -> rd_valid pulses route to the correct owner with one-cycle latency and no overlap.
REQ-033 SHALL pass this test: i_rstn=0 in the cycle after an M1 read grant -> no o_m1_rd_valid, FSM=ARB, counter=0.
REQ-034 SHALL pass this test: M0 write of 0xDEADBEEF with byte_sel=4'b0011 -> o_mem_wr_en=1, o_mem_byte_sel=4'b0011 in the grant cycle, no rd_valid.

Source files
------------

// File: rtl/riscv_dmem_arbiter.sv
// riscv_dmem_arbiter
// Two-master arbiter for a single-ported data memory. M0 is the CPU pipeline
// and normally wins; M1 is the debug/loader port. M1 is protected from
// starvation by a saturating denial counter. M1 can also hold the memory
// exclusively with a lock. Reads return one cycle after the address cycle,
// and the response is routed back to whichever master issued it.
module riscv_dmem_arbiter #(
  parameter int XLEN         = 32,
  parameter int ADDR_BIT     = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_rstn,

  // M0: CPU pipeline
  input  logic                i_m0_req,
  input  logic                i_m0_wr_en,
  input  logic [ADDR_BIT-1:0] i_m0_addr,
  input  logic [3:0]          i_m0_byte_sel,
  input  logic [XLEN-1:0]     i_m0_wr_data,
  output logic                o_m0_gnt,
  output logic                o_m0_rd_valid,
  output logic [XLEN-1:0]     o_m0_rd_data,

  // M1: debug / loader
  input  logic                i_m1_req,
  input  logic                i_m1_wr_en,
  input  logic                i_m1_lock,
  input  logic [ADDR_BIT-1:0] i_m1_addr,
  input  logic [3:0]          i_m1_byte_sel,
  input  logic [XLEN-1:0]     i_m1_wr_data,
  output logic                o_m1_gnt,
  output logic                o_m1_rd_valid,
  output logic [XLEN-1:0]     o_m1_rd_data,

  // Data memory
  output logic [ADDR_BIT-1:0] o_mem_addr,
  output logic                o_mem_wr_en,
  output logic [3:0]          o_mem_byte_sel,
  output logic [XLEN-1:0]     o_mem_wr_data,
  input  logic [XLEN-1:0]     i_mem_rd_data
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic {
    ARB   = 1'b0,  // normal priority arbitration
    LOCK1 = 1'b1   // M1 holds the memory exclusively
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       tag_valid_q, tag_valid_d;
  logic       tag_owner_q, tag_owner_d;  // 0 = M0, 1 = M1
  logic       gnt_m0, gnt_m1;

  // Grant decision, next FSM state, starvation count and read tag.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the
    // case/if tree can leave it unassigned and infer a latch.
    gnt_m0  = 1'b0;
    gnt_m1  = 1'b0;
    state_d = state_q;

    // While reset is low, no access may reach the memory.
    if (i_rstn) begin
      unique case (state_q)
        ARB: begin
          if (i_m1_req && (!i_m0_req || starve_q == STARVE_MAX)) begin
            gnt_m1 = 1'b1;
          end else if (i_m0_req) begin
            gnt_m0 = 1'b1;
          end
          if (gnt_m1 && i_m1_lock) state_d = LOCK1;
        end
        LOCK1: begin
          // The cycle that drops the lock is still arbitrated as locked.
          gnt_m1 = i_m1_req;
          if (!i_m1_lock) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end

    if (i_m1_req && !gnt_m1) begin
      starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 4'd1;
    end else begin
      starve_d = 4'd0;
    end

    tag_valid_d = (gnt_m0 && !i_m0_wr_en) || (gnt_m1 && !i_m1_wr_en);
    tag_owner_d = gnt_m1;
  end

  // Route the granted master's fields to the memory port.
  always_comb begin
    o_mem_addr     = i_m0_addr;
    o_mem_wr_data  = i_m0_wr_data;
    o_mem_wr_en    = 1'b0;
    o_mem_byte_sel = 4'b0000;
    if (gnt_m1) begin
      o_mem_addr     = i_m1_addr;
      o_mem_wr_data  = i_m1_wr_data;
      o_mem_wr_en    = i_m1_wr_en;
      o_mem_byte_sel = i_m1_byte_sel;
    end else if (gnt_m0) begin
      o_mem_wr_en    = i_m0_wr_en;
      o_mem_byte_sel = i_m0_byte_sel;
    end
  end

  // State, starvation counter and read-tag registers.
  always_ff @(posedge i_clk) begin
    // NOTE: reset is synchronous, so i_rstn is tested inside the clocked
    // block and left out of the sensitivity list. State updates use
    // non-blocking assignments so every register samples pre-edge values.
    if (!i_rstn) begin
      state_q     <= ARB;
      starve_q    <= 4'd0;
      tag_valid_q <= 1'b0;
      tag_owner_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
    end
  end

  assign o_m0_gnt = gnt_m0;
  assign o_m1_gnt = gnt_m1;

  // A tag still pending while reset is held is discarded rather than delivered.
  assign o_m0_rd_valid = i_rstn && tag_valid_q && !tag_owner_q;
  assign o_m1_rd_valid = i_rstn && tag_valid_q &&  tag_owner_q;
  assign o_m0_rd_data  = i_mem_rd_data;
  assign o_m1_rd_data  = i_mem_rd_data;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// tb_riscv_dmem_arbiter
// Directed vectors with literal expectations, plus a per-cycle comparison
// against a behavioural model of the arbitration rules. The bench owns the
// data memory. A shadow copy of that memory gives the expected read data.
module tb_riscv_dmem_arbiter;

  localparam int XLEN  = 32;
  localparam int AB    = 12;
  localparam int LIMIT = 4;
  localparam int WORDS = 1 << (AB - 2);

  logic            clk;
  logic            rstn;
  logic            m0_req, m0_wr, m1_req, m1_wr, m1_lock;
  logic [AB-1:0]   m0_addr, m1_addr;
  logic [3:0]      m0_bs, m1_bs;
  logic [XLEN-1:0] m0_wd, m1_wd;
  logic            o_m0_gnt, o_m0_rd_valid, o_m1_gnt, o_m1_rd_valid;
  logic [XLEN-1:0] o_m0_rd_data, o_m1_rd_data;
  logic [AB-1:0]   o_mem_addr;
  logic            o_mem_wr_en;
  logic [3:0]      o_mem_byte_sel;
  logic [XLEN-1:0] o_mem_wr_data;
  logic [XLEN-1:0] mem_rd_data;

  logic [XLEN-1:0] mem    [WORDS];
  logic [XLEN-1:0] shadow [WORDS];

  int n_checks = 0;
  int n_fail   = 0;

  riscv_dmem_arbiter #(.XLEN(XLEN), .ADDR_BIT(AB), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_m0_req(m0_req), .i_m0_wr_en(m0_wr), .i_m0_addr(m0_addr),
    .i_m0_byte_sel(m0_bs), .i_m0_wr_data(m0_wd),
    .o_m0_gnt(o_m0_gnt), .o_m0_rd_valid(o_m0_rd_valid), .o_m0_rd_data(o_m0_rd_data),
    .i_m1_req(m1_req), .i_m1_wr_en(m1_wr), .i_m1_lock(m1_lock), .i_m1_addr(m1_addr),
    .i_m1_byte_sel(m1_bs), .i_m1_wr_data(m1_wd),
    .o_m1_gnt(o_m1_gnt), .o_m1_rd_valid(o_m1_rd_valid), .o_m1_rd_data(o_m1_rd_data),
    .o_mem_addr(o_mem_addr), .o_mem_wr_en(o_mem_wr_en), .o_mem_byte_sel(o_mem_byte_sel),
    .o_mem_wr_data(o_mem_wr_data), .i_mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old_w,
                                            input logic [XLEN-1:0] new_w,
                                            input logic [3:0] bs);
    logic [XLEN-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (bs[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Synchronous memory: read data appears one cycle after the address.
  always @(posedge clk) begin
    mem_rd_data <= mem[o_mem_addr[AB-1:2]];
    if (o_mem_wr_en)
      mem[o_mem_addr[AB-1:2]] <= merge(mem[o_mem_addr[AB-1:2]], o_mem_wr_data, o_mem_byte_sel);
  end

  // Behavioural model: count of consecutive denied M1 cycles, whether M1
  // currently owns the memory, and the read awaiting its response.
  int              deny   = 0;
  bit              locked = 1'b0;
  bit              pend_v = 1'b0;
  bit              pend_o = 1'b0;
  logic [XLEN-1:0] pend_d = '0;

  always @(negedge clk) begin
    bit e0, e1, wr;
    int idx;
    e0 = 1'b0;
    e1 = 1'b0;
    if (rstn) begin
      if (locked)                                      e1 = m1_req;
      else if (m1_req && (!m0_req || deny == LIMIT))   e1 = 1'b1;
      else if (m0_req)                                 e0 = 1'b1;
    end
    check("gnt_m0", o_m0_gnt, e0);
    check("gnt_m1", o_m1_gnt, e1);
    check("mem_wr_en", o_mem_wr_en, e0 ? m0_wr : (e1 ? m1_wr : 1'b0));
    check("mem_byte_sel", o_mem_byte_sel, e0 ? m0_bs : (e1 ? m1_bs : 4'b0));
    check("mem_addr", o_mem_addr, e1 ? m1_addr : m0_addr);
    check("mem_wr_data", o_mem_wr_data, e1 ? m1_wd : m0_wd);
    check("rd_valid_m0", o_m0_rd_valid, rstn && pend_v && !pend_o);
    check("rd_valid_m1", o_m1_rd_valid, rstn && pend_v && pend_o);
    if (rstn && pend_v && !pend_o) check("rd_data_m0", o_m0_rd_data, pend_d);
    if (rstn && pend_v &&  pend_o) check("rd_data_m1", o_m1_rd_data, pend_d);

    if (!rstn) begin
      deny   = 0;
      locked = 1'b0;
      pend_v = 1'b0;
    end else begin
      idx    = e1 ? int'(m1_addr[AB-1:2]) : int'(m0_addr[AB-1:2]);
      wr     = e1 ? m1_wr : m0_wr;
      pend_v = (e0 || e1) && !wr;
      pend_o = e1;
      pend_d = shadow[idx];
      if ((e0 || e1) && wr) shadow[idx] = merge(shadow[idx], e1 ? m1_wd : m0_wd, e1 ? m1_bs : m0_bs);
      if (m1_req && !e1) deny = (deny == LIMIT) ? LIMIT : deny + 1;
      else               deny = 0;
      locked = locked ? m1_lock : (e1 && m1_lock);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_wr = 0; m1_req = 0; m1_wr = 0; m1_lock = 0;
  endtask

  task automatic rd0(input logic [AB-1:0] a);
    m0_req = 1; m0_wr = 0; m0_addr = a; m0_bs = 4'hF;
  endtask

  task automatic rd1(input logic [AB-1:0] a, input logic lk);
    m1_req = 1; m1_wr = 0; m1_addr = a; m1_bs = 4'hF; m1_lock = lk;
  endtask

  // Directed stimulus and literal expectations. Memory word i holds
  // 0x1000_0000 + i, so byte address A reads back as 0x1000_0000 + A/4.
  initial begin
    logic [9:0] m1_turn;
    m1_turn = 10'b10000_10000;
    for (int i = 0; i < WORDS; i++) begin
      mem[i]    = 32'h1000_0000 + i;
      shadow[i] = 32'h1000_0000 + i;
    end
    rstn = 0; idle();
    m0_addr = '0; m1_addr = '0; m0_bs = '0; m1_bs = '0; m0_wd = '0; m1_wd = '0;

    // Reset masks a pending request.
    tick(); rd0(12'h010);
    tick(); #1;
    check("rst_gnt0", o_m0_gnt, 1'b0);
    check("rst_wr_en", o_mem_wr_en, 1'b0);
    check("rst_rdv0", o_m0_rd_valid, 1'b0);

    // Single M0 read of 0x010.
    tick(); rstn = 1; rd0(12'h010); #1;
    check("rd_gnt0", o_m0_gnt, 1'b1);
    check("rd_gnt1", o_m1_gnt, 1'b0);
    tick(); idle(); #1;
    check("rd_valid0", o_m0_rd_valid, 1'b1);
    check("rd_data0", o_m0_rd_data, 32'h1000_0004);
    check("rd_valid1_quiet", o_m1_rd_valid, 1'b0);

    // Continuous contention: four M0 grants, then one forced M1 grant.
    for (int i = 0; i < 10; i++) begin
      tick(); rd0(12'h080 + 12'(4 * i)); rd1(12'h0C0 + 12'(4 * i), 1'b0); #1;
      check("starve_gnt0", o_m0_gnt, !m1_turn[i]);
      check("starve_gnt1", o_m1_gnt,  m1_turn[i]);
    end

    // Locked M1 writes shut M0 out; the unlocking cycle is still locked.
    tick(); idle(); rd0(12'h300);
    m0_req = 0;
    m1_req = 1; m1_wr = 1; m1_lock = 1; m1_addr = 12'h040; m1_bs = 4'hF; m1_wd = 32'hCAFE_0000;
    #1;
    check("lock_gnt1_0", o_m1_gnt, 1'b1);
    for (int i = 1; i < 3; i++) begin
      tick(); m0_req = 1; m1_addr = 12'h040 + 12'(4 * i); m1_wd = 32'hCAFE_0000 + i; #1;
      check("lock_gnt1", o_m1_gnt, 1'b1);
      check("lock_gnt0", o_m0_gnt, 1'b0);
    end
    tick(); m1_req = 0; m1_wr = 0; m1_lock = 0; #1;
    check("unlock_gnt0", o_m0_gnt, 1'b0);
    tick(); #1;
    check("after_lock_gnt0", o_m0_gnt, 1'b1);

    // Partial M0 write, then read it back.
    tick(); idle();
    m0_req = 1; m0_wr = 1; m0_addr = 12'h020; m0_bs = 4'b0011; m0_wd = 32'hDEAD_BEEF; #1;
    check("wr_gnt0", o_m0_gnt, 1'b1);
    check("wr_wr_en", o_mem_wr_en, 1'b1);
    check("wr_byte_sel", o_mem_byte_sel, 4'b0011);
    check("wr_data", o_mem_wr_data, 32'hDEAD_BEEF);
    tick(); rd0(12'h020); #1;
    check("wr_no_rdv0", o_m0_rd_valid, 1'b0);
    tick(); idle(); #1;
    check("wr_readback", o_m0_rd_data, 32'h1000_BEEF);

    // Alternating M0 / M1 reads back to back.
    for (int i = 0; i < 6; i++) begin
      tick(); idle();
      if (i % 2 == 0) rd0(12'h100 + 12'(4 * i));
      else            rd1(12'h100 + 12'(4 * i), 1'b0);
      #1;
      if (i > 0) begin
        check("alt_rdv0", o_m0_rd_valid, (i % 2) == 1);
        check("alt_rdv1", o_m1_rd_valid, (i % 2) == 0);
        check("alt_data", o_m0_rd_data, 32'h1000_0040 + 32'(i - 1));
      end
    end
    tick(); idle(); #1;
    check("alt_last_rdv1", o_m1_rd_valid, 1'b1);
    check("alt_last_data", o_m1_rd_data, 32'h1000_0045);

    // Reset right after a locked M1 read grant drops the response and the lock.
    tick(); rd1(12'h200, 1'b1); #1;
    check("rst_mid_gnt1", o_m1_gnt, 1'b1);
    tick(); rstn = 0; #1;
    check("rst_mid_rdv1", o_m1_rd_valid, 1'b0);
    check("rst_mid_gnt1_off", o_m1_gnt, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(); rstn = 1; rd0(12'h210); rd1(12'h220, 1'b0); #1;
      if (i == 0) check("post_rst_rdv1", o_m1_rd_valid, 1'b0);
      check("post_rst_gnt0", o_m0_gnt, i != 4);
      check("post_rst_gnt1", o_m1_gnt, i == 4);
    end

    // Mixed traffic, checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      tick();
      rstn    = ($urandom_range(0, 39) != 0);
      m0_req  = 1'($urandom_range(0, 1));
      m0_wr   = 1'($urandom_range(0, 1));
      m0_addr = {6'($urandom_range(0, 63)), 4'b0, 2'b00};
      m0_bs   = 4'($urandom);
      m0_wd   = $urandom;
      m1_req  = 1'($urandom_range(0, 1));
      m1_wr   = 1'($urandom_range(0, 1));
      m1_lock = ($urandom_range(0, 3) == 0);
      m1_addr = {6'($urandom_range(0, 63)), 4'b0, 2'b00};
      m1_bs   = 4'($urandom);
      m1_wd   = $urandom;
    end
    tick(); rstn = 1; idle();
    tick(); tick();
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
